// File: rtl/host_loader.sv
// Host command sequencer: writes/reads the CPU's instruction and data memories
// through their external ports and releases the CPU for a bounded cycle count.
module host_loader #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              cpu_enable,
    output logic [ADDR_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic [ADDR_W-1:0] addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ_REQ,
        S_READ_WAIT,
        S_RUN,
        S_RESP
    } state_t;

    state_t            state_q;
    logic              dmem_sel_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  run_n_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              busy_q;
    logic              cpu_enable_q;
    logic [ADDR_W-1:0] addr_ext_q;
    logic              wen_ext_q;
    logic              ren_ext_q;
    logic [DATA_W-1:0] wdata_ext_q;
    logic [ADDR_W-1:0] addr_ext_2_q;
    logic              wen_ext_2_q;
    logic              ren_ext_2_q;
    logic [DATA_W-1:0] wdata_ext_2_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q       <= S_IDLE;
            dmem_sel_q    <= 1'b0;
            cnt_q         <= '0;
            run_n_q       <= '0;
            cmd_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            cpu_enable_q  <= 1'b0;
            addr_ext_q    <= '0;
            wen_ext_q     <= 1'b0;
            ren_ext_q     <= 1'b0;
            wdata_ext_q   <= '0;
            addr_ext_2_q  <= '0;
            wen_ext_2_q   <= 1'b0;
            ren_ext_2_q   <= 1'b0;
            wdata_ext_2_q <= '0;
        end else begin
            // Memory strobes are single-cycle pulses unless re-armed below.
            wen_ext_q   <= 1'b0;
            ren_ext_q   <= 1'b0;
            wen_ext_2_q <= 1'b0;
            ren_ext_2_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        dmem_sel_q  <= cmd_op[0];
                        case (cmd_op)
                            3'd0, 3'd1: begin
                                if (cmd_op[0]) begin
                                    addr_ext_2_q  <= cmd_addr;
                                    wdata_ext_2_q <= cmd_data;
                                    wen_ext_2_q   <= 1'b1;
                                end else begin
                                    addr_ext_q    <= cmd_addr;
                                    wdata_ext_q   <= cmd_data;
                                    wen_ext_q     <= 1'b1;
                                end
                                state_q <= S_WRITE;
                            end
                            3'd2, 3'd3: begin
                                if (cmd_op[0]) begin
                                    addr_ext_2_q <= cmd_addr;
                                    ren_ext_2_q  <= 1'b1;
                                end else begin
                                    addr_ext_q   <= cmd_addr;
                                    ren_ext_q    <= 1'b1;
                                end
                                state_q <= S_READ_REQ;
                            end
                            3'd4: begin
                                cnt_q   <= cmd_data[CNT_W-1:0];
                                run_n_q <= cmd_data[CNT_W-1:0];
                                if (cmd_data[CNT_W-1:0] == '0) begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= '0;
                                    rsp_err_q   <= 1'b0;
                                    state_q     <= S_RESP;
                                end else begin
                                    cpu_enable_q <= 1'b1;
                                    state_q      <= S_RUN;
                                end
                            end
                            default: begin
                                rsp_valid_q <= 1'b1;
                                rsp_data_q  <= '0;
                                rsp_err_q   <= 1'b1;
                                state_q     <= S_RESP;
                            end
                        endcase
                    end
                end
                S_WRITE: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
                    rsp_err_q   <= 1'b0;
                    state_q     <= S_RESP;
                end
                S_READ_REQ: begin
                    state_q <= S_READ_WAIT;
                end
                S_READ_WAIT: begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= dmem_sel_q ? rdata_ext_2 : rdata_ext;
                    rsp_err_q   <= 1'b0;
                    state_q     <= S_RESP;
                end
                S_RUN: begin
                    // Counter holds the enable cycles still owed, including this one.
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        cpu_enable_q <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_data_q   <= DATA_W'(run_n_q);
                        rsp_err_q    <= 1'b0;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign cpu_enable  = cpu_enable_q;
    assign addr_ext    = addr_ext_q;
    assign wen_ext     = wen_ext_q;
    assign ren_ext     = ren_ext_q;
    assign wdata_ext   = wdata_ext_q;
    assign addr_ext_2  = addr_ext_2_q;
    assign wen_ext_2   = wen_ext_2_q;
    assign ren_ext_2   = ren_ext_2_q;
    assign wdata_ext_2 = wdata_ext_2_q;

endmodule

// File: tb/tb_host_loader.sv
// Randomized bench for host_loader: small memories answer the external ports,
// a command-level reference model predicts responses, latency and strobe counts.
module tb_host_loader;

    logic        clk = 1'b0;
    logic        arst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        cpu_enable;
    logic [31:0] addr_ext, wdata_ext, rdata_ext;
    logic        wen_ext, ren_ext;
    logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2;
    logic        wen_ext_2, ren_ext_2;

    host_loader dut (
        .clk(clk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memories attached to the external ports (synchronous read).
    logic [31:0] tb_imem [64];
    logic [31:0] tb_dmem [64];
    always @(posedge clk) begin
        if (wen_ext)   tb_imem[addr_ext[5:0]]   <= wdata_ext;
        if (ren_ext)   rdata_ext                <= tb_imem[addr_ext[5:0]];
        if (wen_ext_2) tb_dmem[addr_ext_2[5:0]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2              <= tb_dmem[addr_ext_2[5:0]];
    end

    // Reference memory contents as the host believes them to be.
    logic [31:0] ref_imem [64];
    logic [31:0] ref_dmem [64];

    // Per-command activity counters, sampled 1 time unit after each rising edge.
    int mon_wen1, mon_wen2, mon_ren1, mon_ren2, mon_en, mon_conf;
    logic [31:0] mon_addr1, mon_addr2, mon_wdata1, mon_wdata2;
    always @(posedge clk) begin
        #1;
        if (wen_ext)   begin mon_wen1++; mon_wdata1 = wdata_ext;   end
        if (wen_ext_2) begin mon_wen2++; mon_wdata2 = wdata_ext_2; end
        if (ren_ext)   mon_ren1++;
        if (ren_ext_2) mon_ren2++;
        if (wen_ext || ren_ext)     mon_addr1 = addr_ext;
        if (wen_ext_2 || ren_ext_2) mon_addr2 = addr_ext_2;
        if (cpu_enable) mon_en++;
        if (cpu_enable && (wen_ext || ren_ext || wen_ext_2 || ren_ext_2)) mon_conf++;
        if ((wen_ext || ren_ext) && (wen_ext_2 || ren_ext_2)) mon_conf++;
    end

    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                           input int hold);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat, e_wen1, e_wen2, e_ren1, e_ren2, e_en, lat, waited;
        exp_data = 32'h0; exp_err = 1'b0; exp_lat = 1;
        e_wen1 = 0; e_wen2 = 0; e_ren1 = 0; e_ren2 = 0; e_en = 0;
        case (op)
            3'd0: begin ref_imem[a[5:0]] = d; exp_lat = 2; e_wen1 = 1; end
            3'd1: begin ref_dmem[a[5:0]] = d; exp_lat = 2; e_wen2 = 1; end
            3'd2: begin exp_data = ref_imem[a[5:0]]; exp_lat = 3; e_ren1 = 1; end
            3'd3: begin exp_data = ref_dmem[a[5:0]]; exp_lat = 3; e_ren2 = 1; end
            3'd4: begin
                e_en     = int'(d[15:0]);
                exp_data = {16'h0, d[15:0]};
                exp_lat  = e_en + 1;
            end
            default: exp_err = 1'b1;
        endcase

        @(negedge clk);
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1; rsp_ready = 1'b0;
        waited = 0;
        while (!cmd_ready && waited < 50) begin @(negedge clk); waited++; end
        check_eq("cmd_accept", {63'h0, cmd_ready}, 64'h1);
        mon_wen1 = 0; mon_wen2 = 0; mon_ren1 = 0; mon_ren2 = 0; mon_en = 0; mon_conf = 0;
        mon_addr1 = 32'hx; mon_addr2 = 32'hx; mon_wdata1 = 32'hx; mon_wdata2 = 32'hx;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
        check_eq("rsp_latency", 64'(lat), 64'(exp_lat));
        check_eq("rsp_data", {32'h0, rsp_data}, {32'h0, exp_data});
        check_eq("rsp_err", {63'h0, rsp_err}, {63'h0, exp_err});
        check_eq("busy_in_resp", {63'h0, busy}, 64'h1);

        // Backpressure: a competing command is offered and must not be consumed.
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr = 32'd63; cmd_data = $urandom;
            @(negedge clk);
            check_eq("hold_valid", {63'h0, rsp_valid}, 64'h1);
            check_eq("hold_data", {32'h0, rsp_data}, {32'h0, exp_data});
            check_eq("hold_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_hs_valid", {63'h0, rsp_valid}, 64'h0);
        check_eq("post_hs_ready", {62'h0, cmd_ready, busy}, 64'h2);

        check_eq("cnt_wen_imem", 64'(mon_wen1), 64'(e_wen1));
        check_eq("cnt_wen_dmem", 64'(mon_wen2), 64'(e_wen2));
        check_eq("cnt_ren_imem", 64'(mon_ren1), 64'(e_ren1));
        check_eq("cnt_ren_dmem", 64'(mon_ren2), 64'(e_ren2));
        check_eq("cnt_enable", 64'(mon_en), 64'(e_en));
        check_eq("port_conflict", 64'(mon_conf), 64'h0);
        if (e_wen1 + e_ren1 > 0) check_eq("addr_imem", {32'h0, mon_addr1}, {32'h0, a});
        if (e_wen2 + e_ren2 > 0) check_eq("addr_dmem", {32'h0, mon_addr2}, {32'h0, a});
        if (e_wen1 > 0) check_eq("wdata_imem", {32'h0, mon_wdata1}, {32'h0, d});
        if (e_wen2 > 0) check_eq("wdata_dmem", {32'h0, mon_wdata2}, {32'h0, d});
        $display("[TB] op=%0d addr=%h data=%h -> rsp_data=%h err=%0d lat=%0d hold=%0d",
                 op, a, d, rsp_data, rsp_err, lat, hold);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctl"},
                 {57'h0, cmd_ready, rsp_valid, rsp_err, busy, cpu_enable, wen_ext | wen_ext_2,
                  ren_ext | ren_ext_2},
                 64'h40);
        check_eq({tag, "_rsp_data"}, {32'h0, rsp_data}, 64'h0);
        check_eq({tag, "_addr"}, {addr_ext, addr_ext_2}, 64'h0);
        check_eq({tag, "_wdata"}, {wdata_ext, wdata_ext_2}, 64'h0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        for (int i = 0; i < 64; i++) begin
            tb_imem[i] = 32'h0; tb_dmem[i] = 32'h0; ref_imem[i] = 32'h0; ref_dmem[i] = 32'h0;
        end
        arst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 32'h0; cmd_data = 32'h0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // Directed scenarios.
        run_cmd(3'd0, 32'h4, 32'h2008_0005, 0);
        run_cmd(3'd1, 32'h10, 32'hDEAD_BEEF, 0);
        run_cmd(3'd3, 32'h10, 32'h0, 0);
        run_cmd(3'd4, 32'h0, 32'd5, 0);
        run_cmd(3'd4, 32'h0, 32'd0, 0);
        run_cmd(3'd4, 32'h0, 32'd1, 0);
        run_cmd(3'd4, 32'h0, 32'hABCD_0003, 1);
        run_cmd(3'd6, 32'h8, 32'h1234_5678, 0);
        run_cmd(3'd2, 32'h4, 32'h0, 4);

        // Reset asserted in the third RUN cycle of N=10.
        @(negedge clk);
        cmd_op = 3'd4; cmd_addr = 32'h0; cmd_data = 32'd10; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("run_enable_c1", {63'h0, cpu_enable}, 64'h1);
        repeat (2) @(negedge clk);
        check_eq("run_enable_c3", {63'h0, cpu_enable}, 64'h1);
        #2 arst = 1'b1;
        #1 check_reset_outputs("arst_in_run");
        @(negedge clk);
        arst = 1'b0;
        rsp_ready = 1'b1;
        quiet = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (rsp_valid || cpu_enable) quiet++;
        end
        rsp_ready = 1'b0;
        check_eq("no_rsp_after_arst", 64'(quiet), 64'h0);
        run_cmd(3'd3, 32'h10, 32'h0, 0);

        // Randomized commands.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, d;
            op = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 62));
            d  = $urandom;
            if (op == 3'd4) d = {d[31:16], 16'($urandom_range(0, 12))};
            run_cmd(op, a, d, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
